// File: rtl/matmul_stream_ctrl.sv
// Streaming front/back end for matmul_top: loads X then Y from one input stream,
// pulses start, waits for done, then streams Z out through a 2-entry skid FIFO.
module matmul_stream_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int MATRIX_SIZE = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [ADDR_WIDTH-1:0] x_wr_addr,
  output logic                  x_wr_en,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [ADDR_WIDTH-1:0] y_wr_addr,
  output logic                  y_wr_en,
  output logic                  start,
  input  logic                  done,
  output logic [ADDR_WIDTH-1:0] z_rd_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic                  busy
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_LAST = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] LP_SIZE = CW'(MATRIX_SIZE);

  typedef enum logic [2:0] {
    S_LOAD_X,
    S_LOAD_Y,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0]         r_wcount, r_rcount, r_ocount;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_fifo_wp, r_fifo_rp;
  logic [1:0]            r_fifo_cnt;
  logic [ADDR_WIDTH-1:0] r_zaddr;
  logic                  r_x_wr_en, r_y_wr_en, r_start;
  logic [DATA_WIDTH-1:0] r_x_din, r_y_din;
  logic [ADDR_WIDTH-1:0] r_x_addr, r_y_addr;

  logic       w_xfer, w_pop, w_last_out, w_issue;
  logic [2:0] w_occ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_LOAD_X;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    w_xfer     = 1'b0;
    w_issue    = 1'b0;
    w_pop      = (r_fifo_cnt != 2'd0) && out_ready;
    w_last_out = w_pop && (r_ocount == LP_LAST);
    // Occupancy seen by the issue rule already discounts this cycle's pop, which
    // keeps output at 1 word/cycle while still bounding FIFO + in-flight to 2.
    w_occ      = 3'(r_fifo_cnt) + 3'(r_inflight) - 3'(w_pop);
    case (r_state)
      S_LOAD_X: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        w_xfer   = in_valid;
        if (in_valid && (r_wcount == LP_LAST)) w_next = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        in_ready = 1'b1;
        w_xfer   = in_valid;
        if (in_valid && (r_wcount == LP_LAST)) w_next = S_START;
      end
      S_START: w_next = S_WAIT;
      S_WAIT:  if (done) w_next = S_DRAIN;
      S_DRAIN: begin
        w_issue = (r_rcount < LP_SIZE) && (w_occ < 3'd2);
        if (w_last_out) w_next = S_LOAD_X;
      end
      default: w_next = S_LOAD_X;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wcount   <= '0;
      r_rcount   <= '0;
      r_ocount   <= '0;
      r_inflight <= 1'b0;
      r_zaddr    <= '0;
      r_x_wr_en  <= 1'b0;
      r_y_wr_en  <= 1'b0;
      r_start    <= 1'b0;
      r_x_din    <= '0;
      r_y_din    <= '0;
      r_x_addr   <= '0;
      r_y_addr   <= '0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_fifo_wp  <= 1'b0;
      r_fifo_rp  <= 1'b0;
      r_fifo_cnt <= '0;
    end else begin
      r_x_wr_en  <= w_xfer && (r_state == S_LOAD_X);
      r_y_wr_en  <= w_xfer && (r_state == S_LOAD_Y);
      r_start    <= (r_state == S_START);
      r_inflight <= w_issue;
      if (w_xfer) begin
        if (r_state == S_LOAD_X) begin
          r_x_din  <= in_data;
          r_x_addr <= r_wcount[ADDR_WIDTH-1:0];
        end else begin
          r_y_din  <= in_data;
          r_y_addr <= r_wcount[ADDR_WIDTH-1:0];
        end
        r_wcount <= (r_wcount == LP_LAST) ? '0 : r_wcount + CW'(1);
      end
      if (w_issue) begin
        r_zaddr  <= r_rcount[ADDR_WIDTH-1:0];
        r_rcount <= r_rcount + CW'(1);
      end
      if (w_pop) r_ocount <= r_ocount + CW'(1);
      if (w_last_out) begin
        r_wcount <= '0;
        r_rcount <= '0;
        r_ocount <= '0;
      end
      if (r_inflight) begin
        r_fifo[r_fifo_wp] <= z_dout;
        r_fifo_wp         <= ~r_fifo_wp;
      end
      if (w_pop) r_fifo_rp <= ~r_fifo_rp;
      case ({r_inflight, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign out_valid = (r_fifo_cnt != 2'd0);
  assign out_data  = r_fifo[r_fifo_rp];
  assign out_last  = out_valid && (r_ocount == LP_LAST);
  assign z_rd_addr = w_issue ? r_rcount[ADDR_WIDTH-1:0] : r_zaddr;
  assign x_din     = r_x_din;
  assign x_wr_addr = r_x_addr;
  assign x_wr_en   = r_x_wr_en;
  assign y_din     = r_y_din;
  assign y_wr_addr = r_y_addr;
  assign y_wr_en   = r_y_wr_en;
  assign start     = r_start;

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed bench for matmul_stream_ctrl with MATRIX_SIZE=4 and a full 2-bit address space.
module tb_matmul_stream_ctrl;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int MS = 4;

  typedef logic [DW-1:0] word8_t [8];

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [DW-1:0] x_din, y_din;
  logic [AW-1:0] x_wr_addr, y_wr_addr, z_rd_addr;
  logic          x_wr_en, y_wr_en, start, busy;
  logic          done = 1'b0;
  logic [DW-1:0] z_dout;

  matmul_stream_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MATRIX_SIZE(MS)
  ) dut (
    .clock    (clock),
    .reset    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .x_din    (x_din),
    .x_wr_addr(x_wr_addr),
    .x_wr_en  (x_wr_en),
    .y_din    (y_din),
    .y_wr_addr(y_wr_addr),
    .y_wr_en  (y_wr_en),
    .start    (start),
    .done     (done),
    .z_rd_addr(z_rd_addr),
    .z_dout   (z_dout),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tmo = 0;
  int hold_viol = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic [DW-1:0] z_mem [MS];
  always @(posedge clock) z_dout <= z_mem[z_rd_addr];

  int xf_c[$];
  int xw_a[$], xw_d[$], xw_c[$];
  int yw_a[$], yw_d[$], yw_c[$];
  int st_c[$];
  int od[$], ol[$], oc[$];

  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clock) begin
    if (rst_n) begin
      if (in_valid && in_ready) xf_c.push_back(cyc);
      if (x_wr_en) begin xw_a.push_back(int'(x_wr_addr)); xw_d.push_back(int'(x_din)); xw_c.push_back(cyc); end
      if (y_wr_en) begin yw_a.push_back(int'(y_wr_addr)); yw_d.push_back(int'(y_din)); yw_c.push_back(cyc); end
      if (start) st_c.push_back(cyc);
      if (out_valid && out_ready) begin
        od.push_back(int'(out_data)); ol.push_back(int'(out_last)); oc.push_back(cyc);
      end
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) hold_viol++;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic clear_logs();
    xf_c.delete(); xw_a.delete(); xw_d.delete(); xw_c.delete();
    yw_a.delete(); yw_d.delete(); yw_c.delete(); st_c.delete();
    od.delete(); ol.delete(); oc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    bit got = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clock);
      if (in_ready) got = 1;
    end
    if (!got) tmo++;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic load8(input word8_t w, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle(1);
      push_word(w[i]);
    end
  endtask

  task automatic pulse_done(output int c0);
    done = 1'b1;
    @(posedge clock); #1;
    done = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 80 && od.size() < n; k++) begin @(posedge clock); #1; end
    if (od.size() < n) tmo++;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 80; k++) begin
      if (in_ready === 1'b1 && busy === 1'b0) break;
      @(posedge clock); #1;
    end
  endtask

  task automatic set_z(input int base);
    for (int i = 0; i < MS; i++) z_mem[i] = DW'(base + i * 'h0111);
  endtask

  task automatic check_tmo(input string name);
    checks++;
    if (tmo != 0) begin errors++; $display("FAIL %s_timeout got %0d expired waits expected 0", name, tmo); end
    tmo = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++;
    if ({out_valid, out_last, x_wr_en, y_wr_en, start} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 00000", {out_valid, out_last, x_wr_en, y_wr_en, start});
    end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
    checks++;
    if ({x_din, x_wr_addr, y_din, y_wr_addr, z_rd_addr} !== '0) begin
      errors++; $display("FAIL reset_bram_ports got %h expected 0", {x_din, x_wr_addr, y_din, y_wr_addr, z_rd_addr});
    end
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_load_basic();
    word8_t w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    clear_logs();
    load8(w, 1'b0);
    idle(3);
    checks++;
    if (xw_a.size() != 4 || yw_a.size() != 4) begin
      errors++; $display("FAIL load_write_count got x=%0d y=%0d expected 4 4", xw_a.size(), yw_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (xw_a[i] != i || xw_d[i] != i + 1 || yw_a[i] != i || yw_d[i] != i + 5) begin
        errors++;
        $display("FAIL load_word%0d got x@%0d=%0d y@%0d=%0d expected x@%0d=%0d y@%0d=%0d",
                 i, xw_a[i], xw_d[i], yw_a[i], yw_d[i], i, i + 1, i, i + 5);
      end
      checks++;
      if (xw_c[i] != xf_c[i] + 1 || yw_c[i] != xf_c[4 + i] + 1) begin
        errors++; $display("FAIL load_latency%0d got x=%0d y=%0d expected x=%0d y=%0d",
                           i, xw_c[i], yw_c[i], xf_c[i] + 1, xf_c[4 + i] + 1);
      end
    end
    checks++;
    if (xf_c[7] - xf_c[0] != 7) begin
      errors++; $display("FAIL load_rate got span %0d expected 7", xf_c[7] - xf_c[0]);
    end
    checks++;
    if (st_c.size() != 1 || st_c[0] != yw_c[3] + 1) begin
      errors++; $display("FAIL load_start got n=%0d cyc=%0d expected n=1 cyc=%0d", st_c.size(), st_c[0], yw_c[3] + 1);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL load_after got ready=%b busy=%b expected 0 1", in_ready, busy);
    end
    check_tmo("load_basic");
  endtask

  task automatic test_drain_basic();
    int viol = 0;
    int c0, rc;
    set_z('hA000);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (out_valid || in_ready || !busy || z_rd_addr != 0) viol++;
    end
    @(posedge clock); #1;
    checks++;
    if (viol != 0 || st_c.size() != 1) begin
      errors++; $display("FAIL wait_quiet got viol=%0d starts=%0d expected 0 1", viol, st_c.size());
    end
    pulse_done(c0);
    wait_out(4);
    rc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (in_ready) begin rc = cyc; break; end
    end
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od[i] != int'(z_mem[i]) || ol[i] != (i == 3 ? 1 : 0) || oc[i] != c0 + 2 + i) begin
        errors++;
        $display("FAIL drain_word%0d got d=%h last=%0d cyc=%0d expected d=%h last=%0d cyc=%0d",
                 i, od[i], ol[i], oc[i], z_mem[i], (i == 3 ? 1 : 0), c0 + 2 + i);
      end
    end
    checks++;
    if (rc != oc[3] + 1) begin errors++; $display("FAIL drain_ready_rise got %0d expected %0d", rc, oc[3] + 1); end
    check_tmo("drain_basic");
  endtask

  task automatic test_load_gaps();
    word8_t w = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707, 16'h0808};
    clear_logs();
    load8(w, 1'b1);
    idle(3);
    checks++;
    if (xw_a.size() != 4 || yw_a.size() != 4 || xf_c.size() != 8) begin
      errors++; $display("FAIL gaps_count got x=%0d y=%0d xfer=%0d expected 4 4 8", xw_a.size(), yw_a.size(), xf_c.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (xw_a[i] != i || xw_d[i] != int'(w[i]) || yw_a[i] != i || yw_d[i] != int'(w[4 + i]) ||
          xw_c[i] != xf_c[i] + 1 || yw_c[i] != xf_c[4 + i] + 1) begin
        errors++;
        $display("FAIL gaps_word%0d got x@%0d=%h y@%0d=%h expected x@%0d=%h y@%0d=%h",
                 i, xw_a[i], xw_d[i], yw_a[i], yw_d[i], i, w[i], i, w[4 + i]);
      end
    end
    checks++;
    if (st_c.size() != 1 || st_c[0] != yw_c[3] + 1) begin
      errors++; $display("FAIL gaps_start got n=%0d cyc=%0d expected n=1 cyc=%0d", st_c.size(), st_c[0], yw_c[3] + 1);
    end
    check_tmo("load_gaps");
  endtask

  task automatic test_backpressure();
    logic [5:0] pat = 6'b101001;
    int c0;
    set_z('h5A00);
    pulse_done(c0);
    for (int k = 0; k < 80 && od.size() < 4; k++) begin
      out_ready = pat[k % 6];
      @(posedge clock); #1;
    end
    if (od.size() < 4) tmo++;
    out_ready = 1'b1;
    idle(4);
    checks++;
    if (od.size() != 4) begin errors++; $display("FAIL bp_count got %0d expected 4", od.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od[i] != int'(z_mem[i]) || ol[i] != (i == 3 ? 1 : 0)) begin
        errors++; $display("FAIL bp_word%0d got d=%h last=%0d expected d=%h last=%0d",
                           i, od[i], ol[i], z_mem[i], (i == 3 ? 1 : 0));
      end
    end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles expected 0", hold_viol); end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle got ready=%b busy=%b expected 1 0", in_ready, busy);
    end
    check_tmo("backpressure");
  endtask

  task automatic test_reset_mid();
    word8_t f = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    clear_logs();
    for (int i = 0; i < 6; i++) push_word(DW'(16'hE000 + i));
    checks++;
    if (y_wr_en !== 1'b1 || y_wr_addr !== 2'd1 || y_din !== 16'hE005) begin
      errors++; $display("FAIL mid_pre got en=%b addr=%0d din=%h expected 1 1 e005", y_wr_en, y_wr_addr, y_din);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({y_wr_en, y_wr_addr, y_din, x_din, busy, start} !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_async got en=%b addr=%0d din=%h xdin=%h busy=%b ready=%b expected 0 0 0 0 0 1",
                         y_wr_en, y_wr_addr, y_din, x_din, busy, in_ready);
    end
    @(negedge clock); @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    clear_logs();
    set_z('h3C00);
    load8(f, 1'b0);
    idle(3);
    checks++;
    if (xw_a.size() != 4 || xw_a[0] != 0 || xw_d[0] != int'(f[0]) || yw_a[0] != 0 || yw_d[0] != int'(f[4])) begin
      errors++; $display("FAIL mid_reload got nx=%0d x0@%0d=%h y0@%0d=%h expected 4 x0@0=%h y0@0=%h",
                         xw_a.size(), xw_a[0], xw_d[0], yw_a[0], yw_d[0], f[0], f[4]);
    end
    checks++;
    if (st_c.size() != 1 || st_c[0] != yw_c[3] + 1) begin
      errors++; $display("FAIL mid_start got n=%0d cyc=%0d expected n=1 cyc=%0d", st_c.size(), st_c[0], yw_c[3] + 1);
    end
    begin
      int c0;
      pulse_done(c0);
    end
    wait_out(4);
    wait_idle();
    checks++;
    if (od[3] != int'(z_mem[3]) || ol[3] != 1) begin
      errors++; $display("FAIL mid_drain got d=%h last=%0d expected d=%h last=1", od[3], ol[3], z_mem[3]);
    end
    check_tmo("reset_mid");
  endtask

  task automatic test_back_to_back();
    word8_t a = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h0A06, 16'h0A07, 16'h0A08};
    word8_t b = '{16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05, 16'h0B06, 16'h0B07, 16'h0B08};
    int c0;
    clear_logs();
    set_z('h7700);
    out_ready = 1'b1;
    load8(a, 1'b0);
    idle(3);
    pulse_done(c0);
    for (int i = 0; i < 8; i++) push_word(b[i]);
    idle(3);
    checks++;
    if (oc.size() != 4 || xf_c[8] != oc[3] + 1) begin
      errors++; $display("FAIL b2b_first_xfer got n=%0d cyc=%0d expected n=4 cyc=%0d", oc.size(), xf_c[8], oc[3] + 1);
    end
    checks++;
    if (xw_a.size() != 8 || xw_a[4] != 0 || xw_d[4] != int'(b[0]) || xw_a[7] != 3 || xw_d[7] != int'(b[3])) begin
      errors++; $display("FAIL b2b_x_writes got n=%0d x4@%0d=%h x7@%0d=%h expected 8 @0=%h @3=%h",
                         xw_a.size(), xw_a[4], xw_d[4], xw_a[7], xw_d[7], b[0], b[3]);
    end
    checks++;
    if (st_c.size() != 2 || st_c[1] != yw_c[7] + 1) begin
      errors++; $display("FAIL b2b_start got n=%0d cyc=%0d expected n=2 cyc=%0d", st_c.size(), st_c[1], yw_c[7] + 1);
    end
    set_z('h1200);
    pulse_done(c0);
    wait_out(8);
    wait_idle();
    checks++;
    if (od[4] != int'(z_mem[0]) || od[7] != int'(z_mem[3]) || ol[7] != 1 || ol[6] != 0) begin
      errors++; $display("FAIL b2b_drain got d4=%h d7=%h l6=%0d l7=%0d expected %h %h 0 1",
                         od[4], od[7], ol[6], ol[7], z_mem[0], z_mem[3]);
    end
    check_tmo("back_to_back");
  endtask

  initial begin
    set_z('h0);
    test_reset();
    test_load_basic();
    test_drain_basic();
    test_load_gaps();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
